// File: rtl/core_pkg.sv
// core_pkg: run-control state encoding and default widths shared by the run controller
package core_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM_WAIT, DONE} run_state_t;
  localparam int PC_WIDTH_DEF = 12;
  localparam int CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable, enabled up-counter that sticks at all-ones
//   clk, reset (async active-low), clr (sync clear, wins over en), en, count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (en && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/run_controller.sv
// run_controller: program counter, FETCH/EXEC/MEM_WAIT sequencing and req/done run handshake
//   in : clk, reset (async active-low), req, pc_load_en, pc_load_value,
//        instr_halt, instr_is_mem, mem_ack
//   out: done, busy, timeout, pc, mem_req, step, cycle_count
//   RUN_CTRL_WATCHDOG_EN: when defined, a run ends with timeout after MAX_CYCLES busy cycles
module run_controller
  import core_pkg::*;
#(
  parameter int          PC_WIDTH   = PC_WIDTH_DEF,
  parameter int          CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned MAX_CYCLES = 32'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  output logic                 done,
  output logic                 busy,
  output logic                 timeout,
  output logic [PC_WIDTH-1:0]  pc,
  input  logic                 pc_load_en,
  input  logic [PC_WIDTH-1:0]  pc_load_value,
  input  logic                 instr_halt,
  input  logic                 instr_is_mem,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic                 step,
  output logic [CNT_WIDTH-1:0] cycle_count
);
  run_state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic done_q, done_d, busy_q, busy_d, timeout_q, timeout_d;
  logic start, run_ok, wd;
  // busy_q mirrors "state is FETCH/EXEC/MEM_WAIT"; dropping req there is an abort
  assign start = state_q == IDLE && req;
  assign run_ok = busy_q && req;
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(MAX_CYCLES - 1);
  assign wd = run_ok && cycle_count == WD_LAST;
`else
  logic unused_max;
  assign unused_max = ^MAX_CYCLES;
  assign wd = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    step = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE: state_d = req ? FETCH : IDLE;
      FETCH: state_d = !req ? IDLE : wd ? DONE : EXEC;
      EXEC, MEM_WAIT:
        if (!req) state_d = IDLE;
        else if (wd) state_d = DONE;
        else if (state_q == EXEC && instr_halt) state_d = DONE;
        else if (state_q == EXEC && !instr_is_mem) begin
          step = 1'b1;
          state_d = FETCH;
        end else begin
          mem_req = 1'b1;
          step = mem_ack;
          state_d = mem_ack ? FETCH : MEM_WAIT;
        end
      DONE: state_d = req ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    pc_d = start ? '0 : step ? (pc_load_en ? pc_load_value : pc_q + 1'b1) : pc_q;
    timeout_d = start ? 1'b0 : wd ? 1'b1 : timeout_q;
    busy_d = state_d inside {FETCH, EXEC, MEM_WAIT};
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      done_q <= done_d;
      busy_q <= busy_d;
      timeout_q <= timeout_d;
    end
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
    .clk(clk),
    .reset(reset),
    .clr(start),
    .en(run_ok),
    .count(cycle_count)
  );
  assign pc = pc_q;
  assign done = done_q;
  assign busy = busy_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed vector table plus hand sequences for reset, wrap, abort and watchdog
module tb_run_controller;
  typedef struct packed {
    logic        req, halt, mem, ack, ld;
    logic [11:0] ldv;
    logic        busy, done, step, mreq;
    logic [11:0] pc;
    logic [15:0] cc;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0, req = 1'b0;
  logic pc_load_en = 1'b0, instr_halt = 1'b0, instr_is_mem = 1'b0, mem_ack = 1'b0;
  logic [11:0] pc_load_value = '0;
  logic done, busy, timeout, mem_req, step;
  logic [11:0] pc;
  logic [15:0] cycle_count;
  logic w_done, w_busy, w_timeout, w_mem_req, w_step;
  logic [11:0] w_pc;
  logic [15:0] w_cc;
  int n_cmp = 0, n_fail = 0;
  vec_t tbl [26];
  always #5 clk = ~clk;
  run_controller dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .busy(busy), .timeout(timeout),
    .pc(pc), .pc_load_en(pc_load_en), .pc_load_value(pc_load_value),
    .instr_halt(instr_halt), .instr_is_mem(instr_is_mem), .mem_req(mem_req),
    .mem_ack(mem_ack), .step(step), .cycle_count(cycle_count)
  );
  run_controller #(.MAX_CYCLES(10)) dut_wd (
    .clk(clk), .reset(reset), .req(req), .done(w_done), .busy(w_busy), .timeout(w_timeout),
    .pc(w_pc), .pc_load_en(pc_load_en), .pc_load_value(pc_load_value),
    .instr_halt(instr_halt), .instr_is_mem(instr_is_mem), .mem_req(w_mem_req),
    .mem_ack(mem_ack), .step(w_step), .cycle_count(w_cc)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic h, input logic m, input logic a,
                       input logic l, input logic [11:0] lv);
    req = r; instr_halt = h; instr_is_mem = m; mem_ack = a; pc_load_en = l; pc_load_value = lv;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    //            req,halt,mem,ack,ld  ldv      busy,done,step,mreq  pc       cc
    tbl[0]  = {5'b10000, 12'h000, 4'b0000, 12'h000, 16'd0};
    tbl[1]  = {5'b10000, 12'h000, 4'b1000, 12'h000, 16'd0};
    tbl[2]  = {5'b10000, 12'h000, 4'b1010, 12'h000, 16'd1};
    tbl[3]  = {5'b10000, 12'h000, 4'b1000, 12'h001, 16'd2};
    tbl[4]  = {5'b10000, 12'h000, 4'b1010, 12'h001, 16'd3};
    tbl[5]  = {5'b10000, 12'h000, 4'b1000, 12'h002, 16'd4};
    tbl[6]  = {5'b10100, 12'h000, 4'b1001, 12'h002, 16'd5};
    tbl[7]  = {5'b10100, 12'h000, 4'b1001, 12'h002, 16'd6};
    tbl[8]  = {5'b10100, 12'h000, 4'b1001, 12'h002, 16'd7};
    tbl[9]  = {5'b10110, 12'h000, 4'b1011, 12'h002, 16'd8};
    tbl[10] = {5'b10110, 12'h000, 4'b1000, 12'h003, 16'd9};
    tbl[11] = {5'b10110, 12'h000, 4'b1011, 12'h003, 16'd10};
    tbl[12] = {5'b10000, 12'h000, 4'b1000, 12'h004, 16'd11};
    tbl[13] = {5'b10001, 12'h07A, 4'b1010, 12'h004, 16'd12};
    tbl[14] = {5'b10000, 12'h000, 4'b1000, 12'h07A, 16'd13};
    tbl[15] = {5'b11100, 12'h000, 4'b1000, 12'h07A, 16'd14};
    tbl[16] = {5'b10000, 12'h000, 4'b0100, 12'h07A, 16'd15};
    tbl[17] = {5'b10000, 12'h000, 4'b0100, 12'h07A, 16'd15};
    tbl[18] = {5'b00000, 12'h000, 4'b0100, 12'h07A, 16'd15};
    tbl[19] = {5'b00000, 12'h000, 4'b0000, 12'h07A, 16'd15};
    tbl[20] = {5'b10000, 12'h000, 4'b0000, 12'h07A, 16'd15};
    tbl[21] = {5'b10000, 12'h000, 4'b1000, 12'h000, 16'd0};
    tbl[22] = {5'b10100, 12'h000, 4'b1001, 12'h000, 16'd1};
    tbl[23] = {5'b00110, 12'h000, 4'b1000, 12'h000, 16'd2};
    tbl[24] = {5'b00000, 12'h000, 4'b0000, 12'h000, 16'd2};
    tbl[25] = {5'b00000, 12'h000, 4'b0000, 12'h000, 16'd2};
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc", 32'(pc), 0);
    chk("rst.busy", 32'(busy), 0);
    @(negedge clk) reset = 1'b1;
    cyc();
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].req, tbl[i].halt, tbl[i].mem, tbl[i].ack, tbl[i].ld, tbl[i].ldv);
      @(negedge clk);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d.done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("v%0d.step", i), 32'(step), 32'(tbl[i].step));
      chk($sformatf("v%0d.mem_req", i), 32'(mem_req), 32'(tbl[i].mreq));
      chk($sformatf("v%0d.pc", i), 32'(pc), 32'(tbl[i].pc));
      chk($sformatf("v%0d.cycle_count", i), 32'(cycle_count), 32'(tbl[i].cc));
      chk($sformatf("v%0d.timeout", i), 32'(timeout), 0);
      cyc();
    end
    drive(1, 0, 0, 0, 0, 12'h000);
    cyc();
    cyc();
    drive(1, 0, 0, 0, 1, 12'hFFF);
    cyc();
    chk("branch_fff.pc", 32'(pc), 32'h0FFF);
    drive(1, 0, 0, 0, 0, 12'h000);
    cyc();
    cyc();
    chk("wrap.pc", 32'(pc), 0);
    cyc();
    drive(1, 0, 0, 0, 1, 12'h005);
    cyc();
    cyc();
    chk("pre_rst.pc", 32'(pc), 5);
    chk("pre_rst.step", 32'(step), 1);
    #3 reset = 1'b0;
    #1;
    chk("async_rst.pc", 32'(pc), 0);
    chk("async_rst.busy", 32'(busy), 0);
    chk("async_rst.done", 32'(done), 0);
    chk("async_rst.step", 32'(step), 0);
    chk("async_rst.mem_req", 32'(mem_req), 0);
    chk("async_rst.cycle_count", 32'(cycle_count), 0);
    chk("async_rst.timeout", 32'(timeout), 0);
    drive(1, 0, 0, 0, 0, 12'h000);
    @(negedge clk) reset = 1'b1;
    cyc();
    chk("restart.pc", 32'(pc), 0);
    chk("restart.busy", 32'(busy), 1);
    chk("restart.fetch_step", 32'(step), 0);
    cyc();
    chk("restart.first_step", 32'(step), 1);
    drive(0, 0, 0, 0, 0, 12'h000);
    cyc();
    chk("abort_exec.busy", 32'(busy), 0);
    chk("abort_exec.done", 32'(done), 0);
    chk("abort_exec.pc", 32'(pc), 0);
    @(negedge clk);
    #3 req = 1'b1;
    #4 req = 1'b0;
    chk("pulse.busy", 32'(busy), 1);
    cyc();
    chk("pulse_abort.busy", 32'(busy), 0);
    chk("pulse_abort.done", 32'(done), 0);
    reset = 1'b0;
    #2;
    @(negedge clk) reset = 1'b1;
    drive(1, 0, 0, 0, 1, 12'h000);
    cyc();
    repeat (9) cyc();
    chk("wd9.cycle_count", 32'(w_cc), 9);
    chk("wd9.busy", 32'(w_busy), 1);
    chk("wd9.done", 32'(w_done), 0);
    cyc();
    chk("wd10.cycle_count", 32'(w_cc), 10);
`ifdef RUN_CTRL_WATCHDOG_EN
    chk("wd10.done", 32'(w_done), 1);
    chk("wd10.timeout", 32'(w_timeout), 1);
    chk("wd10.busy", 32'(w_busy), 0);
`else
    chk("wd10.done", 32'(w_done), 0);
    chk("wd10.timeout", 32'(w_timeout), 0);
    chk("wd10.busy", 32'(w_busy), 1);
`endif
    drive(0, 0, 0, 0, 0, 12'h000);
    cyc();
    chk("wd_end.done", 32'(w_done), 0);
    chk("wd_end.busy", 32'(w_busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/run_controller.md
# run_controller

Multi-cycle run-control unit for the accumulator core, parametrised in PC width and cycle budget. It owns the program counter, sequences each instruction through FETCH/EXEC (plus MEM_WAIT for data-memory instructions), and implements the 4-phase `req`/`done` start handshake. It sits between the top level's `req`/`done` pins and the core datapath. It gates every architectural write through a single `step` strobe, and adds a memory wait-state handshake and an optional watchdog timeout.

## Interface
- `PC_WIDTH`, 12: program counter width; PC wraps modulo 2^PC_WIDTH.
- `CNT_WIDTH`, 16: cycle counter width.
- `MAX_CYCLES`, 16'hFFFF: watchdog budget in cycles, counted from run start (requires `MAX_CYCLES` < 2^CNT_WIDTH).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  run request, level; start on high, acknowledge `done` by dropping.
- `done`  out  1  run finished (HALT or timeout); held until `req` falls.
- `busy`  out  1  high in FETCH, EXEC and MEM_WAIT.
- `timeout`  out  1  run ended by watchdog; valid while `done`=1.
- `pc`  out  PC_WIDTH  current instruction address, to instruction ROM.
- `pc_load_en`  in  1  branch taken, from branching unit.
- `pc_load_value`  in  PC_WIDTH  branch target.
- `instr_halt`  in  1  decoded HALT.
- `instr_is_mem`  in  1  decoded load/store.
- `mem_req`  out  1  data-memory access request.
- `mem_ack`  in  1  data-memory completion.
- `step`  out  1  commit strobe; register, accumulator and memory write enables are ANDed with it.
- `cycle_count`  out  CNT_WIDTH  cycles elapsed in the current or last run.

## Operation
- States: IDLE, FETCH, EXEC, MEM_WAIT, DONE.
- IDLE: if `req`=1 → FETCH; `pc`<=0, `cycle_count`<=0, `timeout`<=0.
- FETCH: one cycle for the synchronous ROM → EXEC.
- EXEC:
  - `instr_halt`=1 → DONE, `step`=0. HALT has priority over mem.
  - Else `instr_is_mem`=0 → `step`=1 → FETCH.
  - Else `mem_req`=1. If `mem_ack`=1 in the same cycle: `step`=1 → FETCH. Otherwise → MEM_WAIT.
- MEM_WAIT: `mem_req`=1 held. On `mem_ack`=1: `step`=1 → FETCH. `mem_ack` outside EXEC/MEM_WAIT is ignored.
- On every `step`: `pc` <= `pc_load_en` ? `pc_load_value` : `pc`+1, with wrap from all-ones to 0.
- DONE: `done`=1. When `req`=0 → IDLE, and `done` falls on the next cycle.
- Abort: `req`=0 while in FETCH, EXEC or MEM_WAIT → IDLE next edge.
  - `step`, `mem_req` forced 0 in that cycle.
  - `pc` and `cycle_count` are frozen.
  - `done` is not asserted.
- `cycle_count` increments every cycle `busy`=1, saturates at all-ones, and holds in DONE/IDLE until the next start.
- `step` and `mem_req` are combinational from state, `req`, `instr_*` and `mem_ack`. All other outputs are registered.

## Timing
- Reset values: all outputs are 0 while `reset`=0, state=IDLE.
- Start latency: `req` high at edge N → `busy`=1 and `pc`=0 after N; first `step` no earlier than edge N+2.
- Throughput: 2 cycles per non-mem instruction; 2+W for a mem instruction with W wait cycles.
- HALT seen in EXEC at edge N → `done`=1 after N.
- A `req` pulse shorter than one cycle in IDLE must still be sampled if high at an edge. A `req` still high in DONE does not restart a run.

## Configuration
- `RUN_CTRL_WATCHDOG_EN` defined:
  - When `cycle_count` = `MAX_CYCLES`-1 while `busy`, the next state is DONE with `timeout`<=1 and `step`=0.
  - Watchdog has priority over HALT and mem.
- Undefined: `timeout` tied to 0, no comparator, runs are unbounded.

## Structure
- `core_pkg`: `run_state_t` enum (IDLE, FETCH, EXEC, MEM_WAIT, DONE) and default width constants `PC_WIDTH_DEF`, `CNT_WIDTH_DEF`.
- Sub-module `sat_counter` (parametrised width: clear, enable, saturating) for `cycle_count`.
- Next-state logic and PC update stay in `run_controller`.

## Test plan
- Reset low mid-run with `pc`=0x005 → all outputs 0 immediately; after release, `req`=1 → `pc`=0 and first `step` 2 cycles later.
- Program of 3 ALU instructions then HALT, no branches → `step` pulses at cycles 2, 4 and 6 after start; `done`=1 with `pc`=3, `cycle_count`=8.
- Mem instruction with `mem_ack` delayed 3 cycles → `mem_req` high 4 cycles, one `step`, then `pc`+1; zero-wait ack → no MEM_WAIT entry.
- `pc`=0xFFF, no branch, `step` → `pc`=0x000. Branch with `pc_load_value`=0x07A → `pc`=0x07A.
- `req` dropped during MEM_WAIT → IDLE next cycle, `mem_req`=0, `done` never asserted. `req` held after `done` → no restart until `req` cycles low then high.
- With `RUN_CTRL_WATCHDOG_EN` and `MAX_CYCLES`=10, infinite branch loop → `done`=1 and `timeout`=1 after 10 busy cycles. Without the macro → `busy` remains 1.
